chime_sched: RTL and testbench

- Buzzer sequencer and arbiter for the digital-clock sounder; runs on the 1 kHz system tick.
- Shares a single buzzer pin between three requesters: alarm-clock ring, hourly chime (beep count = hour) and key click.
- Generates the beep/gap timing and the tone square wave. The buzzer output drives the pin directly.

---
 rtl/chime_sched.sv | 117 +++++++++++
 tb/tb_chime_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/chime_sched.sv
// chime_sched: buzzer sequencer/arbiter for alarm ring, hourly chime and key click
//
// Ports:
//   clk_1k     1 kHz system clock, all state on rising edge
//   cr         asynchronous active-high reset
//   en         sounder enable; 0 forces IDLE and ignores requests
//   bcd_ht     hour tens (BCD, 24 h)
//   bcd_hu     hour units (BCD)
//   chime_req  one-cycle pulse at the top of the hour
//   alarm_req  level, high while the alarm matches or is latched
//   stop       one-cycle pulse that silences the running alarm
//   key_req    one-cycle pulse per key press
//   buzzer     tone output driving the pin
//   busy       high in any state other than IDLE
//   src        owner: 0 none, 1 key, 2 chime, 3 alarm
//
// Optional feature: define QUIET_HOURS_EN to drop chimes at 22, 23 and 00..06.
module chime_sched #(
    parameter int BEEP_MS       = 200,
    parameter int GAP_MS        = 300,
    parameter int AL_BEEP_MS    = 100,
    parameter int AL_PAUSE_MS   = 500,
    parameter int AL_TIMEOUT_MS = 60000,
    parameter int KEY_MS        = 30
) (
    input  logic       clk_1k,
    input  logic       cr,
    input  logic       en,
    input  logic [3:0] bcd_ht,
    input  logic [3:0] bcd_hu,
    input  logic       chime_req,
    input  logic       alarm_req,
    input  logic       stop,
    input  logic       key_req,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] src
);
    typedef enum logic [2:0] {IDLE, KEY_ON, CH_ON, CH_OFF, AL_ON, AL_OFF, AL_PAUSE} state_t;

    state_t      state, nxt;
    logic [15:0] cnt, ring;
    logic [3:0]  left, n;
    logic [1:0]  al_n;
    logic [4:0]  hour;
    logic        alarm_done, hour_ok, quiet, chime_ok, alarm_ok, in_ch, in_al, timeout, al_end;

    // Invalid tens digits are rejected by hour_ok, so truncation of hour is harmless.
    assign hour     = 5'(bcd_ht) * 5'd10 + 5'(bcd_hu);
    assign hour_ok  = (bcd_ht <= 4'd2) && (bcd_hu <= 4'd9) && (hour <= 5'd23);
    assign n        = (hour == 5'd0) ? 4'd12 : (hour > 5'd12) ? 4'(hour - 5'd12) : hour[3:0];
`ifdef QUIET_HOURS_EN
    assign quiet    = (hour >= 5'd22) || (hour <= 5'd6);
`else
    assign quiet    = 1'b0;
`endif
    assign chime_ok = chime_req && hour_ok && !quiet;
    assign alarm_ok = alarm_req && !alarm_done;
    assign in_ch    = (state == CH_ON) || (state == CH_OFF);
    assign in_al    = (state == AL_ON) || (state == AL_OFF) || (state == AL_PAUSE);
    // ring holds the number of alarm cycles so far including the current one
    assign timeout  = ring >= 16'(AL_TIMEOUT_MS);
    assign al_end   = !alarm_req || stop || timeout;

    always_ff @(posedge clk_1k or posedge cr) begin
        if (cr) state <= IDLE;
        else    state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (!en) nxt = IDLE;
        else begin
            case (state)
                IDLE:     nxt = alarm_ok ? AL_ON : chime_ok ? CH_ON : key_req ? KEY_ON : IDLE;
                KEY_ON:   nxt = alarm_ok ? AL_ON : chime_ok ? CH_ON :
                                (cnt >= 16'(KEY_MS - 1)) ? IDLE : KEY_ON;
                CH_ON:    nxt = alarm_ok ? AL_ON : (cnt >= 16'(BEEP_MS - 1)) ?
                                ((left <= 4'd1) ? IDLE : CH_OFF) : CH_ON;
                CH_OFF:   nxt = alarm_ok ? AL_ON : (cnt >= 16'(GAP_MS - 1)) ? CH_ON : CH_OFF;
                AL_ON:    nxt = al_end ? IDLE : (cnt >= 16'(AL_BEEP_MS - 1)) ?
                                ((al_n == 2'd3) ? AL_PAUSE : AL_OFF) : AL_ON;
                AL_OFF:   nxt = al_end ? IDLE : (cnt >= 16'(AL_BEEP_MS - 1)) ? AL_ON : AL_OFF;
                AL_PAUSE: nxt = al_end ? IDLE : (cnt >= 16'(AL_PAUSE_MS - 1)) ? AL_ON : AL_PAUSE;
                default:  nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1k or posedge cr) begin
        if (cr) begin
            cnt        <= '0;
            ring       <= '0;
            left       <= '0;
            al_n       <= '0;
            alarm_done <= 1'b0;
        end else begin
            // cnt restarts on every state change, which also restarts the tone divider
            cnt        <= (nxt != state || nxt == IDLE) ? '0 : (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            ring       <= (nxt == AL_ON && !in_al) ? 16'd1 : (!in_al || nxt == IDLE) ? '0 :
                          (ring == 16'hFFFF) ? ring : ring + 16'd1;
            left       <= (nxt == IDLE) ? '0 : (nxt == CH_ON && !in_ch) ? n :
                          (state == CH_ON && nxt == CH_OFF) ? left - 4'd1 : left;
            al_n       <= (!in_al || nxt == IDLE || nxt == AL_PAUSE) ? '0 :
                          (state == AL_ON && nxt == AL_OFF) ? al_n + 2'd1 : al_n;
            alarm_done <= !alarm_req ? 1'b0 : (in_al && en && (stop || timeout)) ? 1'b1 : alarm_done;
        end
    end

    always_comb begin
        busy   = state != IDLE;
        src    = (state == KEY_ON) ? 2'd1 : in_ch ? 2'd2 : in_al ? 2'd3 : 2'd0;
        // 500 Hz toggles each cycle from 1; 250 Hz is 1,1,0,0 for all but the last chime beep
        buzzer = (state == KEY_ON || state == AL_ON) ? ~cnt[0] :
                 (state == CH_ON) ? ((left == 4'd1) ? ~cnt[0] : ~cnt[1]) : 1'b0;
    end
endmodule

// File: tb/tb_chime_sched.sv
// tb_chime_sched: directed self-checking bench for chime_sched
module tb_chime_sched;
`ifdef QUIET_HOURS_EN
    localparam bit Q = 1'b1;
`else
    localparam bit Q = 1'b0;
`endif

    logic       clk = 1'b0, cr = 1'b1, en = 1'b1;
    logic [3:0] bcd_ht = '0, bcd_hu = '0;
    logic       chime_req = 1'b0, alarm_req = 1'b0, stop = 1'b0, key_req = 1'b0;
    logic       buzzer, busy;
    logic [1:0] src;

    int errs = 0, checks = 0;
    logic wave [0:5999];

    typedef struct {
        logic [3:0] ht;
        logic [3:0] hu;
        int         beeps;
    } vec_t;
    vec_t tbl [8];

    chime_sched dut (
        .clk_1k(clk), .cr(cr), .en(en), .bcd_ht(bcd_ht), .bcd_hu(bcd_hu),
        .chime_req(chime_req), .alarm_req(alarm_req), .stop(stop), .key_req(key_req),
        .buzzer(buzzer), .busy(busy), .src(src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int len, nb, zeros, ones;
        tbl[0] = '{4'd1, 4'd5, 3};
        tbl[1] = '{4'd0, 4'd0, Q ? 0 : 12};
        tbl[2] = '{4'd1, 4'd2, 12};
        tbl[3] = '{4'd1, 4'hA, 0};
        tbl[4] = '{4'd2, 4'd4, 0};
        tbl[5] = '{4'd0, 4'd7, 7};
        tbl[6] = '{4'd1, 4'd3, 1};
        tbl[7] = '{4'd0, 4'd1, Q ? 0 : 1};

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_src", src, 0);
        check("reset_buzzer", buzzer, 0);
        cr = 1'b0;
        @(negedge clk);

        // chime table: busy length and beep count per latched hour
        for (int i = 0; i < 8; i++) begin
            bcd_ht = tbl[i].ht; bcd_hu = tbl[i].hu; chime_req = 1'b1;
            @(negedge clk);
            chime_req = 1'b0;
            check("chime_src", src, tbl[i].beeps > 0 ? 2 : 0);
            len = 0; nb = 0; zeros = 100;
            while (busy && len < 7000) begin
                if (len < 6000) wave[len] = buzzer;
                if (buzzer && zeros >= 10) nb++;
                zeros = buzzer ? 0 : zeros + 1;
                len++;
                @(negedge clk);
            end
            check("chime_len", len, tbl[i].beeps > 0 ? tbl[i].beeps * 500 - 300 : 0);
            check("chime_beeps", nb, tbl[i].beeps);
            if (i == 0) begin
                check("lo_tone_b1", {wave[0], wave[1], wave[2], wave[3]}, 4'b1100);
                check("lo_tone_b2", {wave[500], wave[501], wave[502], wave[503]}, 4'b1100);
                check("chime_gap", wave[350], 0);
                check("hi_tone_b3", {wave[1000], wave[1001], wave[1002], wave[1003]}, 4'b1010);
            end
            repeat (2) @(negedge clk);
        end

        // alarm with stop at cycle 1000
        alarm_req = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 1000; c++) begin
            wave[c] = buzzer;
            if (c == 0) check("al_src", src, 3);
            if (c == 1000) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        check("al_stop_busy", busy, 0);
        check("al_stop_src", src, 0);
        nb = 0; zeros = 100;
        for (int c = 0; c <= 1000; c++) begin
            if (wave[c] && zeros >= 10) nb++;
            zeros = wave[c] ? 0 : zeros + 1;
        end
        check("al_burst", nb, 4);
        check("al_tone", {wave[0], wave[1], wave[2], wave[3]}, 4'b1010);
        check("al_off", wave[150], 0);
        check("al_on2", {wave[200], wave[201]}, 2'b10);
        check("al_on4", wave[600], 1);
        check("al_pause", wave[900], 0);
        repeat (50) @(negedge clk);
        check("al_blocked", busy, 0);
        alarm_req = 1'b0;
        @(negedge clk);
        alarm_req = 1'b1;
        @(negedge clk);
        check("al_rearm_src", src, 3);
        alarm_req = 1'b0;
        @(negedge clk);
        check("al_release", busy, 0);

        // hour 9 chime preempted mid beep 4 by alarm
        bcd_ht = 4'd0; bcd_hu = 4'd9; chime_req = 1'b1;
        @(negedge clk);
        chime_req = 1'b0;
        repeat (1550) @(negedge clk);
        check("ch9_src", src, 2);
        check("ch9_lo_tone", buzzer, 0);
        alarm_req = 1'b1;
        @(negedge clk);
        check("preempt_src", src, 3);
        check("preempt_buz0", buzzer, 1);
        @(negedge clk);
        check("preempt_buz1", buzzer, 0);
        alarm_req = 1'b0;
        @(negedge clk);
        check("preempt_end", busy, 0);
        repeat (20) @(negedge clk);
        check("ch_not_resumed", busy, 0);

        // key click
        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        check("key_src", src, 1);
        len = 0; ones = 0;
        while (busy && len < 100) begin
            ones += int'(buzzer);
            len++;
            @(negedge clk);
        end
        check("key_len", len, 30);
        check("key_ones", ones, 15);

        // chime preempts key at click cycle 10; key during chime is dropped
        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        repeat (10) @(negedge clk);
        bcd_ht = 4'd1; bcd_hu = 4'd5; chime_req = 1'b1;
        @(negedge clk);
        chime_req = 1'b0;
        check("key_preempt_src", src, 2);
        check("key_preempt_buz", buzzer, 1);
        repeat (4) @(negedge clk);
        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        check("key_dropped", src, 2);
        en = 1'b0;
        @(negedge clk);
        check("en_idle", busy, 0);
        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        check("en_ignore", busy, 0);
        en = 1'b1;
        @(negedge clk);

        // async reset between edges during alarm
        alarm_req = 1'b1;
        @(negedge clk);
        check("ar_busy_pre", busy, 1);
        #1 cr = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_buzzer", buzzer, 0);
        check("ar_src", src, 0);
        alarm_req = 1'b0;
        @(negedge clk);
        cr = 1'b0;
        @(negedge clk);

        // ring timeout
        alarm_req = 1'b1;
        @(negedge clk);
        len = 0;
        while (busy && len < 70000) begin
            len++;
            @(negedge clk);
        end
        check("al_timeout_len", len, 60000);
        check("al_timeout_src", src, 0);
        repeat (100) @(negedge clk);
        check("al_timeout_blocked", busy, 0);
        alarm_req = 1'b0;
        @(negedge clk);
        alarm_req = 1'b1;
        @(negedge clk);
        check("al_timeout_rearm", busy, 1);
        alarm_req = 1'b0;
        @(negedge clk);
        check("al_timeout_release", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
